imem_load_arbiter: RTL and testbench
====================================

# imem_load_arbiter

Sequencer that shares the single-port 16-bit instruction memory between the fetch stage and a program-load host. In normal running it forwards fetch addresses to the memory and registers the returned instruction. On a load request it stalls fetch, streams host words into consecutive memory addresses, then inserts flush bubbles before handing the memory back. It sits between the fetch unit/PC and the instruction memory, on the path that replaces the memory's external set/program input.

## Interface
- AW, 16, address width (memory depth 2^AW words)
- DW, 16, instruction width
- FLUSH_CYC, 2, bubble cycles after a load before fetch resumes (0 allowed)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch request this cycle
- f_addr  in  AW  fetch address
- f_inst  out  DW  registered instruction
- f_valid  out  1  f_inst holds a fresh fetch result
- f_stall  out  1  fetch must hold PC
- ld_start  in  1  load-start pulse; samples ld_base, ld_len
- ld_base  in  AW  first write address
- ld_len  in  AW  word count
- ld_data  in  DW  load word
- ld_valid  in  1  ld_data valid
- ld_ready  out  1  word accepted when ld_valid & ld_ready
- ld_busy  out  1  load or flush in progress
- ld_done  out  1  one-cycle completion pulse
- ld_sum  out  DW  load checksum (see Configuration)
- m_addr  out  AW  memory address (combinational)
- m_we  out  1  memory write enable (combinational)
- m_wdata  out  DW  memory write data (combinational)
- m_rdata  in  DW  memory read data, combinational from m_addr

## Operation
- States RUN, LOAD, FLUSH. Reset state RUN.
- RUN: m_addr=f_addr, m_we=0, f_stall=0, ld_ready=0. If f_req: f_inst<=m_rdata, f_valid<=1; else f_valid<=0, f_inst holds.
- RUN & ld_start & ld_len!=0: latch base, len; idx<=0; -> LOAD. Fetch in that same cycle is still served.
- RUN & ld_start & ld_len==0: no writes, ld_done pulses next cycle, stay RUN.
- LOAD: f_stall=1, ld_ready=1, f_valid<=0, f_inst<=0 (nop). On ld_valid: m_we=1, m_addr=(base+idx) mod 2^AW, m_wdata=ld_data, idx++. Accepting word len-1 -> FLUSH (or RUN with ld_done if FLUSH_CYC=0). ld_valid low: no write, wait indefinitely.
- FLUSH: f_stall=1, ld_ready=0, f_valid=0, m_we=0, counts FLUSH_CYC cycles -> RUN; ld_done=1 for the first RUN cycle.
- ld_busy=1 in LOAD and FLUSH.
- ld_start outside RUN ignored; f_req in LOAD/FLUSH ignored (caller holds PC via f_stall).
- Address wrap: base+idx wraps modulo 2^AW; no error.

## Timing
- Reset values: f_inst=0, f_valid=0, f_stall=0, ld_ready=0, ld_busy=0, ld_done=0, ld_sum=0, m_we=0.
- Fetch latency: 1 cycle (f_addr at edge n -> f_inst/f_valid after edge n+1).
- Load throughput: 1 word/cycle; first write the cycle after ld_start.
- Total load busy time: len + stall cycles + FLUSH_CYC.
- f_stall, ld_ready, m_* are combinational from state; f_inst, f_valid, ld_done registered.
- rst_n asserted mid-load: immediate return to RUN, all outputs to reset values; words already written stay in memory; no ld_done.

## Configuration
- IMEM_CHECKSUM_EN defined: ld_sum cleared to 0 on accepted ld_start, accumulates mod-2^DW sum of every accepted load word; stable and valid from the ld_done cycle until next ld_start.
- Not defined: no accumulator; ld_sum tied to 0.

## Test plan
- Fetch: f_req=1, f_addr=0, m_rdata=0x9201 -> next cycle f_inst=0x9201, f_valid=1; f_req=0 -> f_valid=0, f_inst holds.
- Load 3 words base=0x0010, data 0x9201,0x9402,0x1400, ld_valid continuous -> writes at 0x10,0x11,0x12 on consecutive cycles, f_stall=1 for 3+2 cycles, ld_done one cycle, ld_sum=0x3A03 (checksum build).
- ld_valid gaps (1,0,0,1) with len=2 -> exactly 2 writes, LOAD held during gaps, no spurious m_we.
- Wrap: base=0xFFFF, len=2 -> writes to 0xFFFF then 0x0000.
- ld_len=0 -> no m_we, ld_done next cycle, f_stall never asserted; ld_start during LOAD ignored.
- rst_n low after 1 of 4 words -> all outputs reset asynchronously, ld_done never pulses, fetch works next cycle.

Source files
------------

// File: rtl/imem_load_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : imem_load_arbiter_if
//  Purpose  : Bundle of the fetch, program-load and instruction-memory
//             signals around imem_load_arbiter.
//  Modports :
//    slave  - the arbiter: consumes fetch/load requests and memory read
//             data, and drives the fetch result, load handshake and
//             memory address/write signals.
//    master - the environment: fetch unit, load host and memory.
//  Signals  :
//    f_req/f_addr        fetch request and address
//    f_inst/f_valid      registered fetch result
//    f_stall             fetch must hold PC
//    ld_start/base/len   load command (sampled on ld_start)
//    ld_data/ld_valid    load word stream, accepted with ld_ready
//    ld_busy/done/sum    load status, completion pulse, checksum
//    m_addr/we/wdata     memory port (combinational)
//    m_rdata             memory read data (combinational from m_addr)
//  Revision : 1.0  initial release
// ============================================================================
interface imem_load_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_inst;
  logic          f_valid;
  logic          f_stall;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW-1:0] ld_len;
  logic [DW-1:0] ld_data;
  logic          ld_valid;
  logic          ld_ready;
  logic          ld_busy;
  logic          ld_done;
  logic [DW-1:0] ld_sum;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  f_req, f_addr, ld_start, ld_base, ld_len, ld_data, ld_valid, m_rdata,
    output f_inst, f_valid, f_stall, ld_ready, ld_busy, ld_done, ld_sum,
           m_addr, m_we, m_wdata
  );

  modport master (
    output f_req, f_addr, ld_start, ld_base, ld_len, ld_data, ld_valid, m_rdata,
    input  f_inst, f_valid, f_stall, ld_ready, ld_busy, ld_done, ld_sum,
           m_addr, m_we, m_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : imem_load_arbiter
//  Purpose  : Shares a single-port instruction memory between the fetch
//             stage and a program-load host. RUN forwards fetch addresses
//             and registers the instruction; LOAD streams host words into
//             consecutive addresses while stalling fetch; FLUSH inserts
//             FLUSH_CYC bubble cycles before fetch resumes.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - imem_load_arbiter_if.slave (fetch, load, memory)
//  Params   : AW (address width), DW (instruction width),
//             FLUSH_CYC (bubble cycles after a load, 0 allowed)
//  Option   : IMEM_CHECKSUM_EN - when defined, ld_sum carries the
//             mod-2^DW sum of the words of the last load; otherwise 0.
//  Revision : 1.0  initial release
// ============================================================================
module imem_load_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int FLUSH_CYC = 2
) (
  input wire             clk,
  input wire             rst_n,
  imem_load_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // Flush counter runs 0 .. FLUSH_CYC-1; keep at least one bit so the
  // FLUSH_CYC=0 build still elaborates.
  localparam int                c_FW         = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [c_FW-1:0]   c_FLUSH_LAST = c_FW'((FLUSH_CYC > 0) ? (FLUSH_CYC - 1) : 0);
  localparam logic [c_FW-1:0]   c_FONE       = c_FW'(1);
  localparam logic [AW-1:0]     c_ONE        = AW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_base;
  logic [AW-1:0]   r_len;
  logic [AW-1:0]   r_idx;
  logic [c_FW-1:0] r_fcnt;
  logic [DW-1:0]   r_f_inst;
  logic            r_f_valid;
  logic            r_ld_done;

  logic [AW-1:0]   w_m_addr;
  logic            w_m_we;
  logic [DW-1:0]   w_m_wdata;
  logic            w_f_stall;
  logic            w_ld_ready;
  logic            w_start;    // ld_start taken in RUN
  logic            w_accept;   // load word written this cycle
  logic            w_finish;   // load/flush completes at this edge

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state and combinational memory/handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_m_addr    = bus.f_addr;
    w_m_we      = 1'b0;
    w_m_wdata   = '0;
    w_f_stall   = 1'b0;
    w_ld_ready  = 1'b0;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_RUN: begin
        if (bus.ld_start) begin
          w_start = 1'b1;
          if (bus.ld_len != '0) w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_f_stall  = 1'b1;
        w_ld_ready = 1'b1;
        // Base plus index wraps naturally at AW bits.
        w_m_addr   = r_base + r_idx;
        if (bus.ld_valid) begin
          w_accept  = 1'b1;
          w_m_we    = 1'b1;
          w_m_wdata = bus.ld_data;
          if (r_idx == r_len - c_ONE) begin
            if (FLUSH_CYC == 0) begin
              w_state_nxt = S_RUN;
              w_finish    = 1'b1;
            end else begin
              w_state_nxt = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        w_f_stall = 1'b1;
        if (r_fcnt == c_FLUSH_LAST) begin
          w_state_nxt = S_RUN;
          w_finish    = 1'b1;
        end
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Fetch result, load bookkeeping and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_f_inst  <= '0;
      r_f_valid <= 1'b0;
      r_ld_done <= 1'b0;
      r_base    <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_fcnt    <= '0;
    end else begin
      // A zero-length load completes immediately without leaving RUN.
      r_ld_done <= w_finish | (w_start && (bus.ld_len == '0));
      case (r_state)
        S_RUN: begin
          if (bus.f_req) begin
            r_f_inst  <= bus.m_rdata;
            r_f_valid <= 1'b1;
          end else begin
            r_f_valid <= 1'b0;
          end
          if (w_start) begin
            r_base <= bus.ld_base;
            r_len  <= bus.ld_len;
            r_idx  <= '0;
          end
        end
        S_LOAD: begin
          // Present a nop to the pipeline while memory is owned by the host.
          r_f_valid <= 1'b0;
          r_f_inst  <= '0;
          r_fcnt    <= '0;
          if (w_accept) r_idx <= r_idx + c_ONE;
        end
        S_FLUSH: begin
          r_f_valid <= 1'b0;
          r_f_inst  <= '0;
          r_fcnt    <= r_fcnt + c_FONE;
        end
        default: ;
      endcase
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [DW-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_sum <= '0;
    else if (w_start)  r_sum <= '0;
    else if (w_accept) r_sum <= r_sum + bus.ld_data;
  end

  assign bus.ld_sum = r_sum;
`else
  assign bus.ld_sum = '0;
`endif

  assign bus.f_inst   = r_f_inst;
  assign bus.f_valid  = r_f_valid;
  assign bus.f_stall  = w_f_stall;
  assign bus.ld_ready = w_ld_ready;
  assign bus.ld_busy  = (r_state != S_RUN);
  assign bus.ld_done  = r_ld_done;
  assign bus.m_addr   = w_m_addr;
  assign bus.m_we     = w_m_we;
  assign bus.m_wdata  = w_m_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_load_arbiter
//  Purpose  : Self-checking bench for imem_load_arbiter. A driver issues
//             random fetches and loads and pushes expected fetch results,
//             memory writes and load completions into queues; a monitor
//             on the falling edge pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imem_load_arbiter;
  localparam int AW        = 16;
  localparam int DW        = 16;
  localparam int FLUSH_CYC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_load_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  imem_load_arbiter #(.AW(AW), .DW(DW), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- memory and reference model ----------------
  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 0) return 16'h9201;
    return DW'((i * 40503) ^ 23130);
  endfunction

  assign bus.m_rdata = mem[bus.m_addr];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] fq[$];
  logic [DW-1:0] dq[$];
  logic [AW-1:0] wa[$];
  logic          vpat[$];
  logic [DW-1:0] dpat[$];

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0, ready_cnt = 0, busy_cnt = 0;
  logic [DW-1:0] exp_hold = '0;
  logic [DW-1:0] last_sum = '0;
  logic [DW-1:0] mon_d;
  wr_t           mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_hold = '0;
    end else begin
      if (!bus.f_valid && !bus.f_stall) chk("f_inst_hold", bus.f_inst, exp_hold);
      if (bus.f_valid) begin
        if (fq.size() == 0) chk("f_valid_unexpected", bus.f_valid, 1'b0);
        else begin
          mon_d = fq.pop_front();
          chk("f_inst", bus.f_inst, mon_d);
          exp_hold = mon_d;
        end
      end
      if (bus.m_we) begin
        if (wq.size() == 0) chk("m_we_spurious", bus.m_we, 1'b0);
        else begin
          mon_w = wq.pop_front();
          chk("m_addr", bus.m_addr, mon_w.a);
          chk("m_wdata", bus.m_wdata, mon_w.d);
        end
      end
      if (bus.ld_done) begin
        if (dq.size() == 0) chk("ld_done_spurious", bus.ld_done, 1'b0);
        else begin
          mon_d = dq.pop_front();
          chk("ld_sum", bus.ld_sum, mon_d);
          last_sum = mon_d;
        end
      end
      if (bus.f_stall) begin
        stall_cnt++;
        exp_hold = '0;   // load forces a nop into f_inst
      end
      if (bus.ld_ready) ready_cnt++;
      if (bus.ld_busy)  busy_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.f_req    = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
  endtask

  task automatic fetch_burst(input int n);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      if (wa.size() > 0 && $urandom_range(0, 1) == 1) a = wa[$urandom_range(0, wa.size() - 1)];
      else a = AW'($urandom);
      bus.f_req  = ($urandom_range(0, 3) != 0);
      bus.f_addr = a;
      if (bus.f_req) fq.push_back(ref_mem[a]);
      step();
    end
    bus.f_req = 1'b0;
    step();
  endtask

  task automatic do_load(input logic [AW-1:0] base, input logic [AW-1:0] len, input int gap_pct);
    logic [DW-1:0] sum, d;
    logic [AW-1:0] a;
    logic          v;
    int            sent, gaps, s0, r0, b0, exp_st;
    chk("ld_sum_stable", bus.ld_sum, last_sum);
    s0 = stall_cnt; r0 = ready_cnt; b0 = busy_cnt;
    sum = '0; sent = 0; gaps = 0;
    bus.ld_start = 1'b1;
    bus.ld_base  = base;
    bus.ld_len   = len;
    a            = AW'($urandom);
    bus.f_addr   = a;
    bus.f_req    = ($urandom_range(0, 1) == 1);
    if (bus.f_req) fq.push_back(ref_mem[a]);
    step();
    bus.ld_start = 1'b0;
    bus.f_req    = 1'b0;
    while (sent < int'(len)) begin
      if (vpat.size() > 0) v = vpat.pop_front();
      else v = ($urandom_range(0, 99) >= gap_pct);
      if (dpat.size() > 0 && v) d = dpat.pop_front();
      else d = DW'($urandom);
      bus.ld_valid = v;
      bus.ld_data  = d;
      // A second start while loading must be ignored.
      bus.ld_start = (sent == 0 && gaps == 0) || ($urandom_range(0, 7) == 0);
      bus.ld_base  = AW'($urandom);
      bus.ld_len   = AW'($urandom_range(1, 5));
      bus.f_req    = ($urandom_range(0, 1) == 1);
      bus.f_addr   = AW'($urandom);
      if (v) begin
        a = base + AW'(sent);
        wq.push_back('{a: a, d: d});
        ref_mem[a] = d;
        wa.push_back(a);
        sum = sum + d;
        sent++;
      end else begin
        gaps++;
      end
      step();
    end
    idle_inputs();
`ifdef IMEM_CHECKSUM_EN
    dq.push_back(sum);
`else
    dq.push_back('0);
`endif
    for (int n = 0; n < 16 && dq.size() != 0; n++) step();
    chk("ld_done_seen", dq.size(), 0);
    dq.delete();
    exp_st = (len == '0) ? 0 : int'(len) + gaps + FLUSH_CYC;
    chk("stall_cycles", stall_cnt - s0, exp_st);
    chk("busy_cycles", busy_cnt - b0, exp_st);
    chk("ready_cycles", ready_cnt - r0, (len == '0) ? 0 : int'(len) + gaps);
  endtask

  task automatic reset_mid_load();
    logic [DW-1:0] d;
    logic [AW-1:0] base;
    base = 16'h0200;
    bus.ld_start = 1'b1; bus.ld_base = base; bus.ld_len = 16'd4; bus.f_req = 1'b0;
    step();
    bus.ld_start = 1'b0;
    d = DW'($urandom);
    bus.ld_valid = 1'b1; bus.ld_data = d;
    wq.push_back('{a: base, d: d});
    ref_mem[base] = d;
    wa.push_back(base);
    step();
    bus.ld_data = DW'($urandom);   // second word offered when reset hits
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_f_inst",   bus.f_inst,   0);
    chk("rst_f_valid",  bus.f_valid,  0);
    chk("rst_f_stall",  bus.f_stall,  0);
    chk("rst_ld_ready", bus.ld_ready, 0);
    chk("rst_ld_busy",  bus.ld_busy,  0);
    chk("rst_ld_done",  bus.ld_done,  0);
    chk("rst_ld_sum",   bus.ld_sum,   0);
    chk("rst_m_we",     bus.m_we,     0);
    last_sum = '0;
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    idle_inputs();
    bus.f_addr = '0; bus.ld_base = '0; bus.ld_len = '0; bus.ld_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_f_inst",   bus.f_inst,   0);
    chk("init_f_valid",  bus.f_valid,  0);
    chk("init_f_stall",  bus.f_stall,  0);
    chk("init_ld_ready", bus.ld_ready, 0);
    chk("init_ld_busy",  bus.ld_busy,  0);
    chk("init_ld_done",  bus.ld_done,  0);
    chk("init_ld_sum",   bus.ld_sum,   0);
    chk("init_m_we",     bus.m_we,     0);
    rst_n = 1'b1;
    step();

    // Directed fetch of address 0, then idle so f_inst must hold.
    bus.f_req = 1'b1; bus.f_addr = '0;
    fq.push_back(16'h9201);
    step();
    bus.f_req = 1'b0;
    repeat (3) step();

    // Three-word load at 0x0010 with continuous valid.
    dpat.push_back(16'h9201); dpat.push_back(16'h9402); dpat.push_back(16'h1400);
    do_load(16'h0010, 16'd3, 0);
    fetch_burst(10);

    // Valid gaps 1,0,0,1 with len=2.
    vpat.push_back(1'b1); vpat.push_back(1'b0); vpat.push_back(1'b0); vpat.push_back(1'b1);
    do_load(AW'($urandom), 16'd2, 0);

    // Address wrap.
    do_load(16'hFFFF, 16'd2, 20);
    fetch_burst(8);

    // Zero-length load.
    do_load(16'h1234, 16'd0, 0);
    fetch_burst(6);

    // Reset in the middle of a load.
    reset_mid_load();
    fetch_burst(10);

    // Random loads and fetches.
    for (int k = 0; k < 12; k++) begin
      do_load(AW'($urandom), AW'($urandom_range(0, 8)), 30);
      fetch_burst($urandom_range(3, 10));
    end

    repeat (3) step();
    chk("queues_empty", fq.size() + wq.size() + dq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
